// File: rtl/cpu_pkg.sv
// Shared constants for the five-stage MIPS core: widths, the bit positions in the
// decoded control bundle, and the encodings for the EX operand forwarding selects.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  // ctrl = {alu_op[1:0], reg_dst, alu_src, mem_to_reg, mem_write, mem_read, reg_write}
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_ALU_OP     = 6;

  localparam logic [1:0] FWD_ID_EX  = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;
endpackage

// File: rtl/id_ex_reg_fwd_sel.sv
// Forwarding comparator for one EX operand. The newer EX/MEM result wins over
// MEM/WB, and register 0 is never forwarded.
module fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic              i_exmem_wr,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic              i_memwb_wr,
  output logic [1:0]        o_sel
);
  import cpu_pkg::*;

  logic w_ex_hit;
  logic w_wb_hit;

  assign w_ex_hit = i_exmem_wr && (i_exmem_rd != '0) && (i_exmem_rd == i_src);
  assign w_wb_hit = i_memwb_wr && (i_memwb_rd != '0) && (i_memwb_rd == i_src);

  always_comb begin
    o_sel = FWD_ID_EX;
    if (w_ex_hit)      o_sel = FWD_EX_MEM;
    else if (w_wb_hit) o_sel = FWD_MEM_WB;
  end
endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with operand forwarding selects and load-use detection.
// Define ID_EX_HAZARD_EN to enable internal load-use bubbles; otherwise stall_o is 0.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              exmem_wr_i,
  input  logic              memwb_wr_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rs_addr_o,
  output logic [REG_AW-1:0] rt_addr_o,
  output logic [REG_AW-1:0] dst_addr_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o
);
  import cpu_pkg::*;

  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [REG_AW-1:0] r_dst_addr;
  logic [CTRL_W-1:0] r_ctrl;

  logic              w_hazard;
  logic              w_bubble;
  logic [REG_AW-1:0] w_dst_sel;

`ifdef ID_EX_HAZARD_EN
  // A load in EX whose target is read by the instruction now in ID.
  assign w_hazard = r_valid && r_ctrl[CTRL_MEM_READ] && valid_i &&
                    (r_rt_addr != '0) &&
                    ((r_rt_addr == rs_addr_i) || (r_rt_addr == rt_addr_i));
`else
  assign w_hazard = 1'b0;
`endif

  assign w_bubble  = flush_i || (!stall_i && w_hazard);
  assign w_dst_sel = ctrl_i[CTRL_REG_DST] ? rd_addr_i : rt_addr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs_addr  <= '0;
      r_rt_addr  <= '0;
      r_dst_addr <= '0;
    end else if (w_bubble || !stall_i) begin
      // Bubbles still take the data fields; only valid and ctrl are cleared.
      r_valid    <= w_bubble ? 1'b0 : valid_i;
      r_ctrl     <= (w_bubble || !valid_i) ? '0 : ctrl_i;
      r_rs_data  <= rs_data_i;
      r_rt_data  <= rt_data_i;
      r_imm      <= imm_i;
      r_rs_addr  <= rs_addr_i;
      r_rt_addr  <= rt_addr_i;
      r_dst_addr <= w_dst_sel;
    end
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_src      (r_rs_addr),
    .i_exmem_rd (exmem_rd_i),
    .i_exmem_wr (exmem_wr_i),
    .i_memwb_rd (memwb_rd_i),
    .i_memwb_wr (memwb_wr_i),
    .o_sel      (fwd_a_o)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_src      (r_rt_addr),
    .i_exmem_rd (exmem_rd_i),
    .i_exmem_wr (exmem_wr_i),
    .i_memwb_rd (memwb_rd_i),
    .i_memwb_wr (memwb_wr_i),
    .o_sel      (fwd_b_o)
  );

  assign valid_o    = r_valid;
  assign ctrl_o     = r_ctrl;
  assign rs_data_o  = r_rs_data;
  assign rt_data_o  = r_rt_data;
  assign imm_o      = r_imm;
  assign rs_addr_o  = r_rs_addr;
  assign rt_addr_o  = r_rt_addr;
  assign dst_addr_o = r_dst_addr;
  assign stall_o    = w_hazard;
endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: vector table through a scoreboard queue, then
// hand sequences for forwarding, load-use, stall/flush interaction and reset.
module tb_id_ex_reg;
`ifdef ID_EX_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i, exmem_rd_i, memwb_rd_i;
  logic [7:0]  ctrl_i;
  logic        exmem_wr_i, memwb_wr_i;
  logic        valid_o, stall_o;
  logic [31:0] rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_addr_o, rt_addr_o, dst_addr_o;
  logic [7:0]  ctrl_o;
  logic [1:0]  fwd_a_o, fwd_b_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  id_ex_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .ctrl_i(ctrl_i), .exmem_rd_i(exmem_rd_i), .memwb_rd_i(memwb_rd_i),
    .exmem_wr_i(exmem_wr_i), .memwb_wr_i(memwb_wr_i), .valid_o(valid_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .dst_addr_o(dst_addr_o),
    .ctrl_o(ctrl_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o)
  );

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs, rt, rd;
    logic [7:0]  ctrl;
    logic        chk_data;
    logic        e_valid;
    logic [7:0]  e_ctrl;
    logic [4:0]  e_dst, e_rs, e_rt;
    logic [31:0] e_rs_d, e_rt_d, e_imm;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [7:0] c, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] d);
    valid_i = v; ctrl_i = c; rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd;
    rs_data_i = d; rt_data_i = ~d; imm_i = d ^ 32'h0000_ffff;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic v,
                              input logic [31:0] d, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [7:0] c, input logic cd,
                              input logic ev, input logic [7:0] ec, input logic [4:0] edst,
                              input logic [4:0] ers, input logic [4:0] ert, input logic [31:0] ed);
    vec_t r;
    r.stall = st; r.flush = fl; r.valid = v;
    r.rs_d = d; r.rt_d = ~d; r.imm = d ^ 32'h0000_ffff;
    r.rs = rs; r.rt = rt; r.rd = rd; r.ctrl = c; r.chk_data = cd;
    r.e_valid = ev; r.e_ctrl = ec; r.e_dst = edst; r.e_rs = ers; r.e_rt = ert;
    r.e_rs_d = ed; r.e_rt_d = ~ed; r.e_imm = ed ^ 32'h0000_ffff;
    return r;
  endfunction

  initial begin
    // No vector carries mem_read into EX, so the table never triggers a hazard.
    //            st fl v  data          rs  rt  rd  ctrl   cd ev ectl   edst ers ert edata
    vecs[0]  = mk(0, 0, 1, 32'h1111_0001, 1,  3,  7, 8'h21, 1, 1, 8'h21, 7,  1,  3,  32'h1111_0001);
    vecs[1]  = mk(0, 0, 1, 32'h2222_0002, 4,  3,  7, 8'h11, 1, 1, 8'h11, 3,  4,  3,  32'h2222_0002);
    vecs[2]  = mk(0, 0, 1, 32'h3333_0003, 10, 11, 12, 8'hC5, 1, 1, 8'hC5, 11, 10, 11, 32'h3333_0003);
    vecs[3]  = mk(1, 0, 1, 32'h4444_0004, 20, 21, 22, 8'h21, 1, 1, 8'hC5, 11, 10, 11, 32'h3333_0003);
    vecs[4]  = mk(1, 0, 0, 32'h5555_0005, 23, 24, 25, 8'h00, 1, 1, 8'hC5, 11, 10, 11, 32'h3333_0003);
    vecs[5]  = mk(1, 0, 1, 32'h6666_0006, 26, 27, 28, 8'h61, 1, 1, 8'hC5, 11, 10, 11, 32'h3333_0003);
    vecs[6]  = mk(0, 0, 1, 32'h7777_0007, 13, 14, 15, 8'h61, 1, 1, 8'h61, 15, 13, 14, 32'h7777_0007);
    vecs[7]  = mk(1, 1, 1, 32'h8888_0008, 16, 17, 18, 8'h21, 0, 0, 8'h00, 0,  0,  0,  32'h0);
    vecs[8]  = mk(0, 1, 1, 32'h9999_0009, 16, 17, 18, 8'h21, 0, 0, 8'h00, 0,  0,  0,  32'h0);
    vecs[9]  = mk(0, 0, 0, 32'hAAAA_000A, 19, 20, 20, 8'hFF, 1, 0, 8'h00, 20, 19, 20, 32'hAAAA_000A);
    vecs[10] = mk(0, 0, 1, 32'hBBBB_000B, 0,  0,  0,  8'h01, 1, 1, 8'h01, 0,  0,  0,  32'hBBBB_000B);

    // Reset with every input nonzero.
    rst_i = 1; stall_i = 0; flush_i = 0;
    drive_id(1, 8'hFF, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF);
    exmem_rd_i = 5'd9; exmem_wr_i = 1; memwb_rd_i = 5'd9; memwb_wr_i = 1;
    tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ctrl", 32'(ctrl_o), 32'd0);
    chk("rst_rs_data", rs_data_o, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_dst", 32'(dst_addr_o), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a_o), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst_i = 0; exmem_wr_i = 0; memwb_wr_i = 0; exmem_rd_i = 0; memwb_rd_i = 0;

    // Vector table through the scoreboard.
    for (int i = 0; i < 11; i++) begin
      stall_i = vecs[i].stall; flush_i = vecs[i].flush; valid_i = vecs[i].valid;
      rs_data_i = vecs[i].rs_d; rt_data_i = vecs[i].rt_d; imm_i = vecs[i].imm;
      rs_addr_i = vecs[i].rs; rt_addr_i = vecs[i].rt; rd_addr_i = vecs[i].rd;
      ctrl_i = vecs[i].ctrl;
      sb.push_back(vecs[i]);
      tick();
      begin
        vec_t e;
        e = sb.pop_front();
        chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(e.e_valid));
        chk($sformatf("v%0d_ctrl", i), 32'(ctrl_o), 32'(e.e_ctrl));
        chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'd0);
        if (e.chk_data) begin
          chk($sformatf("v%0d_dst", i), 32'(dst_addr_o), 32'(e.e_dst));
          chk($sformatf("v%0d_rs", i), 32'(rs_addr_o), 32'(e.e_rs));
          chk($sformatf("v%0d_rt", i), 32'(rt_addr_o), 32'(e.e_rt));
          chk($sformatf("v%0d_rs_d", i), rs_data_o, e.e_rs_d);
          chk($sformatf("v%0d_rt_d", i), rt_data_o, e.e_rt_d);
          chk($sformatf("v%0d_imm", i), imm_o, e.e_imm);
        end
      end
    end
    stall_i = 0; flush_i = 0;

    // Forwarding priority and register 0 exclusion.
    drive_id(1, 8'h01, 5'd5, 5'd6, 5'd0, 32'h1);
    tick();
    exmem_rd_i = 5; exmem_wr_i = 1; memwb_rd_i = 5; memwb_wr_i = 1; #1;
    chk("fwd_a_exmem", 32'(fwd_a_o), 32'd1);
    chk("fwd_b_none", 32'(fwd_b_o), 32'd0);
    exmem_wr_i = 0; #1;
    chk("fwd_a_memwb", 32'(fwd_a_o), 32'd2);
    memwb_wr_i = 0; #1;
    chk("fwd_a_off", 32'(fwd_a_o), 32'd0);
    exmem_rd_i = 6; exmem_wr_i = 1; memwb_wr_i = 1; #1;
    chk("fwd_a_split", 32'(fwd_a_o), 32'd2);
    chk("fwd_b_split", 32'(fwd_b_o), 32'd1);
    exmem_wr_i = 0; memwb_wr_i = 0;
    drive_id(1, 8'h01, 5'd0, 5'd0, 5'd0, 32'h2);
    tick();
    exmem_rd_i = 0; exmem_wr_i = 1; memwb_rd_i = 0; memwb_wr_i = 1; #1;
    chk("fwd_a_r0", 32'(fwd_a_o), 32'd0);
    chk("fwd_b_r0", 32'(fwd_b_o), 32'd0);
    exmem_wr_i = 0; memwb_wr_i = 0;

    // Load-use: lw $2 then a reader of $2.
    drive_id(1, 8'h0B, 5'd1, 5'd2, 5'd0, 32'h3);
    tick();
    drive_id(1, 8'h01, 5'd2, 5'd4, 5'd9, 32'h4); #1;
    chk("lu_stall", 32'(stall_o), 32'(HZ));
    tick();
    chk("lu_bubble_valid", 32'(valid_o), HZ ? 32'd0 : 32'd1);
    chk("lu_bubble_ctrl", 32'(ctrl_o), HZ ? 32'd0 : 32'h01);
    chk("lu_stall_drop", 32'(stall_o), 32'd0);
    tick();
    chk("lu_dep_valid", 32'(valid_o), 32'd1);
    chk("lu_dep_ctrl", 32'(ctrl_o), 32'h01);
    chk("lu_dep_rs", 32'(rs_addr_o), 32'd2);
    chk("lu_dep_stall", 32'(stall_o), 32'd0);

    // Load into $0 never stalls.
    drive_id(1, 8'h0B, 5'd1, 5'd0, 5'd0, 32'h5);
    tick();
    drive_id(1, 8'h01, 5'd0, 5'd0, 5'd9, 32'h6); #1;
    chk("lu_r0_stall", 32'(stall_o), 32'd0);
    tick();
    chk("lu_r0_valid", 32'(valid_o), 32'd1);

    // stall_i together with a hazard: hold, stall_o stays up.
    drive_id(1, 8'h0B, 5'd1, 5'd2, 5'd0, 32'h7);
    tick();
    drive_id(1, 8'h01, 5'd3, 5'd2, 5'd9, 32'h8); stall_i = 1; #1;
    chk("sh_stall", 32'(stall_o), 32'(HZ));
    tick();
    chk("sh_hold_ctrl", 32'(ctrl_o), 32'h0B);
    chk("sh_stall_kept", 32'(stall_o), 32'(HZ));
    stall_i = 0;

    // flush_i together with a hazard: bubble, stall_o from current contents.
    flush_i = 1; #1;
    chk("fh_stall", 32'(stall_o), 32'(HZ));
    tick();
    chk("fh_valid", 32'(valid_o), 32'd0);
    chk("fh_ctrl", 32'(ctrl_o), 32'd0);
    flush_i = 0;

    // Reset mid-operation.
    drive_id(1, 8'h0B, 5'd1, 5'd2, 5'd3, 32'h9);
    tick();
    chk("mid_valid_pre", 32'(valid_o), 32'd1);
    rst_i = 1;
    tick();
    chk("mid_valid", 32'(valid_o), 32'd0);
    chk("mid_ctrl", 32'(ctrl_o), 32'd0);
    chk("mid_rt", 32'(rt_addr_o), 32'd0);
    chk("mid_stall", 32'(stall_o), 32'd0);
    rst_i = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
